// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// instr_sequencer_if
//   Signal bundle between the instruction sequencer and its environment
//   (instruction memory, controller, datapath, resume logic).
//
//   Fetch side     : mem_req, mem_addr (to memory), mem_ack, mem_rdata (from memory)
//   Decode outputs : opcode, operand (instruction register fields)
//   Controller in  : jump, skip, Halt, acc_zero, go
//   Status         : exec (commit strobe), halted, pc
//
//   master : the sequencer itself
//   slave  : the surrounding system (memory / controller / testbench)
// ---------------------------------------------------------------------------
interface instr_sequencer_if;
  logic       mem_req;
  logic [4:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [2:0] opcode;
  logic [4:0] operand;
  logic       jump;
  logic       skip;
  logic       Halt;
  logic       acc_zero;
  logic       go;
  logic       exec;
  logic       halted;
  logic [4:0] pc;

  modport master (
    output mem_req, mem_addr, opcode, operand, exec, halted, pc,
    input  mem_ack, mem_rdata, jump, skip, Halt, acc_zero, go
  );

  modport slave (
    input  mem_req, mem_addr, opcode, operand, exec, halted, pc,
    output mem_ack, mem_rdata, jump, skip, Halt, acc_zero, go
  );
endinterface

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Fetch/decode/execute sequencer for a small accumulator CPU. It fetches
//   one 8-bit instruction word per instruction from a 32-word memory, holds
//   it in the instruction register (IR), gives the registered controller one
//   DECODE cycle to capture the opcode, then opens a one-cycle EXEC window in
//   which the controller's jump/skip/Halt outputs and acc_zero decide the
//   next program counter.
//
//   Ports:
//     clk  - single clock, rising-edge
//     rst  - synchronous active-high reset
//     bus  - instr_sequencer_if.master:
//              mem_req/mem_addr/mem_ack/mem_rdata : fetch handshake
//              opcode/operand                     : IR fields
//              jump/skip/Halt/acc_zero            : controller decision inputs
//              go                                 : resume from HALTED
//              exec/halted/pc                     : status outputs
//
//   Note: the controller's "jump" input means skip-next-if-zero (SKZ) and its
//   "skip" input means unconditional jump to operand (JMP); the names follow
//   the controller's port naming, not the behaviour.
// ---------------------------------------------------------------------------
module instr_sequencer (
  input  logic                clk,
  input  logic                rst,
  instr_sequencer_if.master   bus
);

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc, pc_nxt;
  logic [DATA_W-1:0]   ir, ir_nxt;
  logic                mem_req_c;
  logic                exec_c;
  logic                halted_c;

  // Program counter advance; the ADDR_W-bit result wraps naturally modulo 32.
  function automatic logic [ADDR_W-1:0] pc_advance(input logic [ADDR_W-1:0] base,
                                                   input logic [ADDR_W-1:0] step);
    return base + step;
  endfunction

  // State, PC and IR registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

  // Next-state, PC/IR update and output decode
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    mem_req_c = 1'b0;
    exec_c    = 1'b0;
    halted_c  = 1'b0;

    case (state)
      FETCH: begin
        mem_req_c = 1'b1;
        // Wait states: pc and IR hold until memory accepts the request.
        if (bus.mem_ack) begin
          ir_nxt    = bus.mem_rdata;
          state_nxt = DECODE;
        end
      end

      DECODE: begin
        state_nxt = EXEC;
      end

      EXEC: begin
        exec_c = 1'b1;
        // Halt wins over the unconditional jump, which wins over SKZ.
        if (bus.Halt) begin
          pc_nxt    = pc_advance(pc, 5'd1);
          state_nxt = HALTED;
        end else if (bus.skip) begin
          pc_nxt    = ir[ADDR_W-1:0];
          state_nxt = FETCH;
        end else if (bus.jump && bus.acc_zero) begin
          pc_nxt    = pc_advance(pc, 5'd2);
          state_nxt = FETCH;
        end else begin
          pc_nxt    = pc_advance(pc, 5'd1);
          state_nxt = FETCH;
        end
      end

      HALTED: begin
        halted_c = 1'b1;
        if (bus.go) begin
          state_nxt = FETCH;
        end
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase

    // The reset cycle must not present a fetch or a commit strobe even
    // though the state register may still hold FETCH/EXEC.
    if (rst) begin
      mem_req_c = 1'b0;
      exec_c    = 1'b0;
      halted_c  = 1'b0;
    end
  end

  assign bus.mem_req  = mem_req_c;
  assign bus.mem_addr = pc;
  assign bus.opcode   = ir[DATA_W-1:ADDR_W];
  assign bus.operand  = ir[ADDR_W-1:0];
  assign bus.exec     = exec_c;
  assign bus.halted   = halted_c;
  assign bus.pc       = pc;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001: clk  input  1  single clock; all state changes on rising edge.
REQ-002: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003: mem_req  output  1  instruction-fetch request to instruction memory.
REQ-004: mem_addr  output  5  fetch address, equal to pc while mem_req is high.
REQ-005: mem_ack  input  1  memory accepts request; mem_rdata valid in the same cycle.
REQ-006: mem_rdata  input  8  instruction word: [7:5] opcode, [4:0] operand address.
REQ-007: opcode  output  3  instruction-register opcode field, fed to controller.
REQ-008: operand  output  5  instruction-register address field, fed to datapath.
REQ-009: jump  input  1  controller output, high for SKZ (skip next if ACC zero).
REQ-010: skip  input  1  controller output, high for JMP (unconditional jump to operand).
REQ-011: Halt  input  1  controller output, high for HLT.
REQ-012: acc_zero  input  1  accumulator equals 8'h00.
REQ-013: go  input  1  resume request while halted.
REQ-014: exec  output  1  one-cycle strobe; controller outputs valid, datapath may commit.
REQ-015: halted  output  1  sequencer is in HALTED state.
REQ-016: pc  output  5  current program counter.

Function
REQ-017: States SHALL be FETCH, DECODE, EXEC, HALTED; state encoding is free.
REQ-018: FETCH: mem_req=1, mem_addr=pc; SHALL stay in FETCH until mem_ack=1, holding pc constant (arbitrary wait states).
REQ-019: On the FETCH cycle with mem_ack=1, IR SHALL load mem_rdata and state SHALL go to DECODE.
REQ-020: opcode/operand SHALL be driven from IR only; they change only on IR load.
REQ-021: DECODE SHALL last exactly one cycle (allows the registered controller to capture opcode), then EXEC.
REQ-022: EXEC SHALL last exactly one cycle with exec=1; jump, skip, Halt, acc_zero sampled only in EXEC.
REQ-023: End of EXEC, priority Halt > skip > jump: Halt -> pc<=pc+1, state HALTED; skip -> pc<=operand, FETCH; jump&acc_zero -> pc<=pc+2, FETCH; otherwise pc<=pc+1, FETCH.
REQ-024: pc arithmetic SHALL be modulo 32 (31+1=0, 31+2=1, 30+2=0).
REQ-025: HALTED: mem_req=0, halted=1, pc and IR held; go=1 SHALL move to FETCH next cycle at held pc.
REQ-026: go SHALL be ignored outside HALTED; mem_ack SHALL be ignored outside FETCH.
REQ-027: mem_req SHALL be 0 in DECODE, EXEC, HALTED; exec SHALL be 0 outside EXEC.
REQ-028: Instruction latency, ack-to-ack with zero wait states: 3 cycles (FETCH, DECODE, EXEC).
REQ-029: jump asserted with acc_zero=0 SHALL behave as a normal pc+1 advance.

Reset
REQ-030: rst=1 SHALL force state FETCH, pc=0, IR=8'h00, exec=0, halted=0; mem_req SHALL be 0 in the reset cycle and 1 in the first cycle after rst deasserts.
REQ-031: rst SHALL override all other inputs in any state, including mid-fetch with mem_ack high; no IR load occurs.
REQ-032: IR=8'h00 after reset decodes as HLT, but it SHALL NOT halt the sequencer because Halt is sampled only in EXEC.

Verification
REQ-033: Reset, memory acks immediately, word 8'h41 (ADD 1) at addr 0 -> mem_req 1 cycle, opcode=3'b010 and operand=1 from next cycle, exec 2 cycles after ack, pc=1, next fetch addr 1.
REQ-034: Word 8'hE5 (JMP 5) at addr 3 with skip=1 in EXEC -> pc=5, next mem_addr=5; with pc=31 and no control, the next fetch is at addr 0.
REQ-035: SKZ at pc=30 with jump=1, acc_zero=1 -> pc=0; repeat with acc_zero=0 -> pc=31.
REQ-036: HLT at pc=7 with Halt=1 -> halted=1, pc=8, mem_req stays 0 for 10 cycles; go=1 -> fetch from addr 8; go pulsed while not halted has no effect.
REQ-037: mem_ack delayed 4 cycles -> mem_req and mem_addr held stable for 5 cycles, no exec pulse; rst asserted in the 3rd wait cycle -> pc=0, IR=8'h00, fetch restarts at addr 0.
REQ-038: Halt, skip, and jump all high in EXEC -> HALTED with pc=pc+1, with no jump taken.
